// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams a RAM address range out through a skid FIFO
// RAM_RD_OUTPUT_REG_EN: when defined, the RAM read latency is 2 cycles instead of 1.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);
`ifdef RAM_RD_OUTPUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   left_q;
    logic [RD_LAT-1:0]     pipe_vld;
    logic [RD_LAT-1:0]     pipe_last;
    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   head;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         occ;
    logic [CW:0]           outstanding;
    logic                  accept, last_issue, last_hs, fifo_wr, fifo_rd;

    // Occupancy plus every read still travelling through the RAM pipeline
    always_comb begin
        outstanding = {1'b0, occ};
        for (int i = 0; i < RD_LAT; i++)
            outstanding = outstanding + (CW+1)'(pipe_vld[i]);
    end

    assign accept      = (state_q == IDLE) && start && (length != '0);
    assign last_issue  = ram_rd_en && (left_q == (ADDR_WIDTH+1)'(1));
    assign busy        = (state_q != IDLE);
    assign ram_rd_addr = addr_q;
    assign fifo_wr     = pipe_vld[RD_LAT-1];
    assign head        = fifo_mem[rd_ptr];
    assign m_valid     = (occ != '0);
    assign m_data      = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_last      = m_valid && head[DATA_WIDTH];
    assign fifo_rd     = m_valid && m_ready;
    assign last_hs     = fifo_rd && m_last;

    always_comb begin
        state_d   = state_q;
        ram_rd_en = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = READ;
            READ: begin
                ram_rd_en = (outstanding < (CW+1)'(FIFO_DEPTH));
                if (ram_rd_en && (left_q == (ADDR_WIDTH+1)'(1))) state_d = DRAIN;
            end
            DRAIN: if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            left_q    <= '0;
            pipe_vld  <= '0;
            pipe_last <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= last_hs || ((state_q == IDLE) && start && (length == '0));
            if (accept) begin
                addr_q <= start_addr;
                left_q <= length;
            end else if (ram_rd_en) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                left_q <= left_q - (ADDR_WIDTH+1)'(1);
            end
            pipe_vld[0]  <= ram_rd_en;
            pipe_last[0] <= last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
            occ <= occ + CW'(fifo_wr) - CW'(fifo_rd);
        end
    end

    // Storage needs no reset: contents are only visible through m_valid
    always_ff @(posedge rd_clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= {pipe_last[RD_LAT-1], ram_rd_data};
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - randomized self-checking bench for ram_stream_reader
module tb_ram_stream_reader;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int FD = 4;
`ifdef RAM_RD_OUTPUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          m_ready = 1'b0;
    logic          busy, done, ram_rd_en, m_valid, m_last;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data, m_data;
    logic [DW-1:0] ram_q1 = '0;
    logic [DW-1:0] ram_q2 = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            got_a[$];
    int cyc, done_cnt, done_cyc, first_v, max_out, stall_bad, busy_gap;
    logic busy_at_done;

    always #5 rd_clk = ~rd_clk;

    ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .start_addr(start_addr),
        .length(length), .busy(busy), .done(done), .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    function automatic logic [DW-1:0] ram_word(input int a);
        return DW'(255 - (a % 256));
    endfunction

    always @(posedge rd_clk) begin
        if (ram_rd_en) ram_q1 <= ram_word(int'(ram_rd_addr));
        ram_q2 <= ram_q1;
    end
    assign ram_rd_data = (RD_LAT == 2) ? ram_q2 : ram_q1;

    // Drives one transfer and records what the sink and RAM port observed.
    task automatic run(input int a, input int len, input int mode, input int restart_at, input int limit);
        int issued, popped, extra;
        logic prev_stall, pl;
        logic [DW-1:0] pd;
        got_d.delete(); got_l.delete(); got_a.delete();
        issued = 0; popped = 0; extra = -1; prev_stall = 1'b0; pd = '0; pl = 1'b0;
        cyc = 0; done_cnt = 0; done_cyc = -1; first_v = -1; max_out = 0;
        stall_bad = 0; busy_gap = 0; busy_at_done = 1'b1;
        start = 1'b1; start_addr = AW'(a); length = (AW+1)'(len);
        while (cyc < limit && extra != 0) begin
            @(negedge rd_clk);
            cyc++;
            if (cyc == restart_at) begin
                start = 1'b1; start_addr = AW'(5); length = (AW+1)'(3);
            end else start = 1'b0;
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = cyc[0];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall && (!m_valid || m_data !== pd || m_last !== pl)) stall_bad++;
            if (m_valid && first_v < 0) first_v = cyc;
            if (ram_rd_en) begin got_a.push_back(int'(ram_rd_addr)); issued++; end
            if (issued - popped > max_out) max_out = issued - popped;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data); got_l.push_back(m_last); popped++;
            end
            if (done_cyc < 0 && !done && !busy) busy_gap++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
            end
            prev_stall = m_valid && !m_ready; pd = m_data; pl = m_last;
            if (extra > 0) extra--;
            else if (done && extra < 0) extra = 3;
        end
        start = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_stream(input string name, input int a, input int len, input int mode, input int restart_at);
        int n;
        run(a, len, mode, restart_at, 4 * len + 40);
        checks++;
        if (done_cyc < 0) begin errors++; $display("FAIL %s done: not seen in %0d cycles", name, cyc); end
        checks++;
        if (got_d.size() != len) begin errors++; $display("FAIL %s word_count: got %0d expected %0d", name, got_d.size(), len); end
        n = (got_d.size() < len) ? got_d.size() : len;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_d[i] !== ram_word((a + i) % 1024) || got_l[i] !== (i == len - 1)) begin
                errors++;
                $display("FAIL %s word %0d: got data %0d last %b expected data %0d last %b",
                         name, i, got_d[i], got_l[i], ram_word((a + i) % 1024), (i == len - 1));
            end
        end
        checks++;
        if (got_a.size() != len) begin errors++; $display("FAIL %s read_count: got %0d expected %0d", name, got_a.size(), len); end
        n = (got_a.size() < len) ? got_a.size() : len;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_a[i] != (a + i) % 1024) begin
                errors++; $display("FAIL %s addr %0d: got %0d expected %0d", name, i, got_a[i], (a + i) % 1024);
            end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt); end
        checks++;
        if (max_out > FD) begin errors++; $display("FAIL %s occupancy: got %0d expected <= %0d", name, max_out, FD); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL %s stall_hold: got %0d changes expected 0", name, stall_bad); end
        checks++;
        if (busy_at_done !== 1'b0 || busy_gap != 0) begin
            errors++; $display("FAIL %s busy: at_done %b gaps %0d expected 0 and 0", name, busy_at_done, busy_gap);
        end
    endtask

    task automatic test_reset();
        int a;
        bit seen;
        rd_rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge rd_clk);
        checks++;
        if ({busy, done, ram_rd_en, m_valid, m_last, ram_rd_addr, m_data} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {busy, done, ram_rd_en, m_valid, m_last, ram_rd_addr, m_data});
        end
        a = int'($urandom_range(0, 1023));
        rd_rst = 1'b0; start = 1'b1; start_addr = AW'(a); length = (AW+1)'(1); m_ready = 1'b1;
        @(negedge rd_clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL first_start: busy %b expected 1", busy); end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) begin seen = 1; break; end
            if (m_valid) begin
                checks++;
                if (m_data !== ram_word(a) || m_last !== 1'b1) begin
                    errors++; $display("FAIL first_word: got %0d last %b expected %0d last 1", m_data, m_last, ram_word(a));
                end
            end
            @(negedge rd_clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL first_done: not seen expected within 20 cycles"); end
        m_ready = 1'b0;
        @(negedge rd_clk);
    endtask

    task automatic test_zero_length();
        int dcnt, en_seen, busy_seen;
        logic d1;
        dcnt = 0; en_seen = 0; busy_seen = 0; d1 = 1'b0;
        start = 1'b1; start_addr = AW'($urandom_range(0, 1023)); length = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge rd_clk);
            start = 1'b0;
            if (c == 1) d1 = done;
            if (done) dcnt++;
            if (ram_rd_en) en_seen++;
            if (busy) busy_seen++;
        end
        checks++;
        if (d1 !== 1'b1) begin errors++; $display("FAIL zero_len_done: got %b expected 1", d1); end
        checks++;
        if (dcnt != 1) begin errors++; $display("FAIL zero_len_pulses: got %0d expected 1", dcnt); end
        checks++;
        if (en_seen != 0 || busy_seen != 0) begin
            errors++; $display("FAIL zero_len_idle: reads %0d busy %0d expected 0 0", en_seen, busy_seen);
        end
    endtask

    task automatic test_throughput();
        test_stream("full_1024", 0, 1024, 0, -1);
        checks++;
        if (first_v != RD_LAT + 2) begin errors++; $display("FAIL first_latency: got %0d expected %0d", first_v, RD_LAT + 2); end
        checks++;
        if (done_cyc != RD_LAT + 2 + 1024) begin
            errors++; $display("FAIL throughput: done at %0d expected %0d", done_cyc, RD_LAT + 2 + 1024);
        end
    endtask

    task automatic test_reset_mid();
        int hs, dcnt, vcnt;
        bit ok;
        hs = 0; ok = 0; dcnt = 0; vcnt = 0;
        start = 1'b1; start_addr = AW'($urandom_range(0, 1023)); length = (AW+1)'(10); m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge rd_clk);
            start = 1'b0;
            if (m_valid && m_ready) hs++;
            if (hs == 3) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_mid_words: got %0d expected 3", hs); end
        @(negedge rd_clk);
        rd_rst = 1'b1;
        @(negedge rd_clk);
        checks++;
        if ({busy, done, ram_rd_en, m_valid, m_last, ram_rd_addr, m_data} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got %h expected 0", {busy, done, ram_rd_en, m_valid, m_last, ram_rd_addr, m_data});
        end
        rd_rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge rd_clk);
            if (done) dcnt++;
            if (m_valid) vcnt++;
        end
        checks++;
        if (dcnt != 0 || vcnt != 0) begin errors++; $display("FAIL reset_mid_quiet: done %0d valid %0d expected 0 0", dcnt, vcnt); end
        test_stream("after_reset", int'($urandom_range(0, 1023)), 2, 0, -1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            test_stream("random", int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)), 2, -1);
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_stream("wrap", 1020, 8, 0, -1);
        test_stream("stall_toggle", int'($urandom_range(0, 1023)), 16, 1, -1);
        test_zero_length();
        test_stream("restart_ignored", 100, 12, 0, 3);
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
